reg_file_sb: RTL and testbench

Parametrised integer register file for the RV32IM pipeline, with two combinational read ports and one write-back port. It adds a per-register pending-write scoreboard so the decode stage can detect RAW hazards and stall. Write-to-read bypass lets a value arriving in write-back reach decode in the same cycle. It sits between decode (reads, reservations) and write-back.

---
 rtl/rv32im_pkg.sv | 11 +
 rtl/sb_counter.sv | 38 +++
 rtl/reg_file_sb.sv | 121 ++++++++++++
 tb/tb_reg_file_sb.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rv32im_pkg.sv
// Shared constants and types for the RV32IM integer datapath.
package rv32im_pkg;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int AW       = $clog2(NREGS);
    localparam int PEND_MAX = 3;

    typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down counter tracking outstanding writes to one register.
// Simultaneous inc and dec cancel out; clr has priority over both.
module sb_counter #(
    parameter  int PEND_MAX = 3,
    localparam int PW       = $clog2(PEND_MAX + 1)
) (
    input  logic          CLK,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [PW-1:0] cnt_o
);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // Next count: step up or down, held at the limits.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != PW'(PEND_MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge CLK) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with two bypassed read ports, one write-back port
// and a per-register pending-write scoreboard for RAW hazard detection.
module reg_file_sb
    import rv32im_pkg::*;
#(
    parameter  int XLEN     = rv32im_pkg::XLEN,
    parameter  int NREGS    = rv32im_pkg::NREGS,
    parameter  int PEND_MAX = rv32im_pkg::PEND_MAX,
    localparam int AW       = $clog2(NREGS),
    localparam int PW       = $clog2(PEND_MAX + 1)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [AW-1:0]   RD_ADDR1,
    input  logic [AW-1:0]   RD_ADDR2,
    output logic [XLEN-1:0] RD_DATA1,
    output logic [XLEN-1:0] RD_DATA2,
    output logic            RD_BUSY1,
    output logic            RD_BUSY2,
    input  logic            RSV_EN,
    input  logic [AW-1:0]   RSV_ADDR,
    output logic            RSV_READY,
    input  logic            WB_EN,
    input  logic [AW-1:0]   WB_ADDR,
    input  logic [XLEN-1:0] WB_DATA,
    output logic            ERR
);

    logic [XLEN-1:0] reg_q [NREGS];
    logic [PW-1:0]   pend_w [NREGS];
    logic            err_q;
    logic            err_d;
    logic            rsv_acc;
    logic            wb_live;

    // A write-back to x0 is a no-op for both storage and the scoreboard.
    assign wb_live = WB_EN && (WB_ADDR != '0);

    // Full-counter reservations are still fine when write-back frees a slot
    // in the same cycle: inc and dec cancel and the count stays at its limit.
    assign RSV_READY = !RESET && ((RSV_ADDR == '0) ||
                                  (pend_w[RSV_ADDR] < PW'(PEND_MAX)) ||
                                  (WB_EN && (WB_ADDR == RSV_ADDR)));
    assign rsv_acc   = RSV_EN && RSV_READY && (RSV_ADDR != '0);

    // x0 never has anything pending.
    assign pend_w[0] = '0;

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_pend
            sb_counter #(
                .PEND_MAX (PEND_MAX)
            ) u_cnt (
                .CLK   (CLK),
                .clr_i (RESET),
                .inc_i (rsv_acc && (RSV_ADDR == AW'(gi))),
                .dec_i (WB_EN && (WB_ADDR == AW'(gi))),
                .cnt_o (pend_w[gi])
            );
        end
    endgenerate

    // Register storage: cleared on reset, written by write-back except x0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                reg_q[i] <= '0;
            end
        end else if (wb_live) begin
            reg_q[WB_ADDR] <= WB_DATA;
        end
    end

    // Read port 1: x0 reads zero, in-flight write-back wins over storage.
    always_comb begin
        RD_DATA1 = reg_q[RD_ADDR1];
        if (RD_ADDR1 == '0) begin
            RD_DATA1 = '0;
        end else if (WB_EN && (WB_ADDR == RD_ADDR1)) begin
            RD_DATA1 = WB_DATA;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        RD_DATA2 = reg_q[RD_ADDR2];
        if (RD_ADDR2 == '0) begin
            RD_DATA2 = '0;
        end else if (WB_EN && (WB_ADDR == RD_ADDR2)) begin
            RD_DATA2 = WB_DATA;
        end
    end

    // Busy unless the only outstanding write is being bypassed right now;
    // with more than one pending, the bypassed value is already stale.
    assign RD_BUSY1 = !RESET && (RD_ADDR1 != '0) && (pend_w[RD_ADDR1] != '0) &&
                      !(WB_EN && (WB_ADDR == RD_ADDR1) && (pend_w[RD_ADDR1] == PW'(1)));
    assign RD_BUSY2 = !RESET && (RD_ADDR2 != '0) && (pend_w[RD_ADDR2] != '0) &&
                      !(WB_EN && (WB_ADDR == RD_ADDR2) && (pend_w[RD_ADDR2] == PW'(1)));

    // Orphan write-back: nothing reserved and nothing reserving it now.
    always_comb begin
        err_d = err_q;
        if (wb_live && (pend_w[WB_ADDR] == '0) &&
            !(rsv_acc && (RSV_ADDR == WB_ADDR))) begin
            err_d = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed testbench for reg_file_sb: reset, bypass, saturation,
// multiple outstanding writes, x0 handling, orphan write-back, mid-run reset.
module tb_reg_file_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [AW-1:0]   RD_ADDR1, RD_ADDR2, RSV_ADDR, WB_ADDR;
    logic [XLEN-1:0] RD_DATA1, RD_DATA2, WB_DATA;
    logic            RD_BUSY1, RD_BUSY2, RSV_EN, RSV_READY, WB_EN, ERR;

    int checks = 0;
    int errors = 0;

    reg_file_sb dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .RD_ADDR1  (RD_ADDR1),
        .RD_ADDR2  (RD_ADDR2),
        .RD_DATA1  (RD_DATA1),
        .RD_DATA2  (RD_DATA2),
        .RD_BUSY1  (RD_BUSY1),
        .RD_BUSY2  (RD_BUSY2),
        .RSV_EN    (RSV_EN),
        .RSV_ADDR  (RSV_ADDR),
        .RSV_READY (RSV_READY),
        .WB_EN     (WB_EN),
        .WB_ADDR   (WB_ADDR),
        .WB_DATA   (WB_DATA),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        step();
        RSV_ADDR = 5'd1; RD_ADDR1 = 5'd1; RD_ADDR2 = 5'd2;
        #1;
        checks++; if (RSV_READY !== 1'b0) begin errors++; $display("FAIL reset_rsv_ready_low got=%b exp=0", RSV_READY); end
        checks++; if (RD_BUSY1 !== 1'b0 || RD_BUSY2 !== 1'b0) begin errors++; $display("FAIL reset_busy_low got=%b%b exp=00", RD_BUSY1, RD_BUSY2); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", ERR); end
        RESET = 1'b0;
        for (int a = 0; a < 32; a++) begin
            RD_ADDR1 = 5'(a); RD_ADDR2 = 5'(31 - a);
            #1;
            checks++; if (RD_DATA1 !== 32'h0 || RD_DATA2 !== 32'h0) begin errors++; $display("FAIL reset_read a=%0d got=%h/%h exp=0", a, RD_DATA1, RD_DATA2); end
            checks++; if (RD_BUSY1 !== 1'b0 || RD_BUSY2 !== 1'b0) begin errors++; $display("FAIL reset_read_busy a=%0d got=%b%b exp=00", a, RD_BUSY1, RD_BUSY2); end
        end
        checks++; if (RSV_READY !== 1'b1) begin errors++; $display("FAIL reset_rsv_ready_after got=%b exp=1", RSV_READY); end
        $display("test_reset done");
    endtask

    task automatic test_bypass();
        RSV_EN = 1'b1; RSV_ADDR = 5'd5; #1;
        checks++; if (RSV_READY !== 1'b1) begin errors++; $display("FAIL bypass_rsv_ready got=%b exp=1", RSV_READY); end
        step();
        RSV_EN = 1'b0; RD_ADDR1 = 5'd5; #1;
        checks++; if (RD_BUSY1 !== 1'b1) begin errors++; $display("FAIL bypass_busy_pending got=%b exp=1", RD_BUSY1); end
        WB_EN = 1'b1; WB_ADDR = 5'd5; WB_DATA = 32'hDEADBEEF; #1;
        checks++; if (RD_DATA1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_data got=%h exp=deadbeef", RD_DATA1); end
        checks++; if (RD_BUSY1 !== 1'b0) begin errors++; $display("FAIL bypass_busy got=%b exp=0", RD_BUSY1); end
        step();
        WB_EN = 1'b0; #1;
        checks++; if (RD_DATA1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_stored got=%h exp=deadbeef", RD_DATA1); end
        checks++; if (RD_BUSY1 !== 1'b0) begin errors++; $display("FAIL bypass_pend_zero got=%b exp=0", RD_BUSY1); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL bypass_err got=%b exp=0", ERR); end
        $display("test_bypass done");
    endtask

    task automatic test_saturate();
        RSV_EN = 1'b1; RSV_ADDR = 5'd7; RD_ADDR1 = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (RSV_READY !== 1'b1) begin errors++; $display("FAIL sat_fill k=%0d got=%b exp=1", k, RSV_READY); end
            step();
        end
        #1;
        checks++; if (RSV_READY !== 1'b0) begin errors++; $display("FAIL sat_full got=%b exp=0", RSV_READY); end
        step();
        #1;
        checks++; if (RSV_READY !== 1'b0) begin errors++; $display("FAIL sat_hold got=%b exp=0", RSV_READY); end
        checks++; if (RD_BUSY1 !== 1'b1) begin errors++; $display("FAIL sat_busy got=%b exp=1", RD_BUSY1); end
        WB_EN = 1'b1; WB_ADDR = 5'd7; WB_DATA = 32'h77; #1;
        checks++; if (RSV_READY !== 1'b1) begin errors++; $display("FAIL sat_wb_ready got=%b exp=1", RSV_READY); end
        checks++; if (RD_BUSY1 !== 1'b1) begin errors++; $display("FAIL sat_wb_busy got=%b exp=1", RD_BUSY1); end
        step();
        WB_EN = 1'b0; #1;
        checks++; if (RSV_READY !== 1'b0) begin errors++; $display("FAIL sat_still_full got=%b exp=0", RSV_READY); end
        RSV_EN = 1'b0;
        WB_EN = 1'b1;
        for (int k = 0; k < 2; k++) begin
            WB_DATA = 32'(k); step();
        end
        WB_DATA = 32'h77; #1;
        checks++; if (RD_BUSY1 !== 1'b0 || RD_DATA1 !== 32'h77) begin errors++; $display("FAIL sat_drain_last got=%b/%h exp=0/77", RD_BUSY1, RD_DATA1); end
        step();
        WB_EN = 1'b0; #1;
        checks++; if (RD_BUSY1 !== 1'b0) begin errors++; $display("FAIL sat_drained got=%b exp=0", RD_BUSY1); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL sat_err got=%b exp=0", ERR); end
        $display("test_saturate done");
    endtask

    task automatic test_multi_pending();
        RSV_EN = 1'b1; RSV_ADDR = 5'd9;
        step(); step();
        RSV_EN = 1'b0; RD_ADDR2 = 5'd9;
        WB_EN = 1'b1; WB_ADDR = 5'd9; WB_DATA = 32'h11; #1;
        checks++; if (RD_BUSY2 !== 1'b1) begin errors++; $display("FAIL multi_busy_pend2 got=%b exp=1", RD_BUSY2); end
        checks++; if (RD_DATA2 !== 32'h11) begin errors++; $display("FAIL multi_bypass1 got=%h exp=11", RD_DATA2); end
        step();
        WB_EN = 1'b0; #1;
        checks++; if (RD_BUSY2 !== 1'b1) begin errors++; $display("FAIL multi_busy_pend1 got=%b exp=1", RD_BUSY2); end
        checks++; if (RD_DATA2 !== 32'h11) begin errors++; $display("FAIL multi_stored1 got=%h exp=11", RD_DATA2); end
        WB_EN = 1'b1; WB_DATA = 32'h22; #1;
        checks++; if (RD_BUSY2 !== 1'b0) begin errors++; $display("FAIL multi_busy_last got=%b exp=0", RD_BUSY2); end
        checks++; if (RD_DATA2 !== 32'h22) begin errors++; $display("FAIL multi_bypass2 got=%h exp=22", RD_DATA2); end
        step();
        WB_EN = 1'b0; #1;
        checks++; if (RD_BUSY2 !== 1'b0 || RD_DATA2 !== 32'h22) begin errors++; $display("FAIL multi_final got=%b/%h exp=0/22", RD_BUSY2, RD_DATA2); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL multi_err got=%b exp=0", ERR); end
        $display("test_multi_pending done");
    endtask

    task automatic test_x0();
        WB_EN = 1'b1; WB_ADDR = 5'd0; WB_DATA = 32'hFFFFFFFF;
        RSV_EN = 1'b1; RSV_ADDR = 5'd0; RD_ADDR1 = 5'd0; #1;
        checks++; if (RSV_READY !== 1'b1) begin errors++; $display("FAIL x0_ready got=%b exp=1", RSV_READY); end
        checks++; if (RD_DATA1 !== 32'h0 || RD_BUSY1 !== 1'b0) begin errors++; $display("FAIL x0_read got=%h/%b exp=0/0", RD_DATA1, RD_BUSY1); end
        step();
        WB_EN = 1'b0; RSV_EN = 1'b0; #1;
        checks++; if (RD_DATA1 !== 32'h0) begin errors++; $display("FAIL x0_after got=%h exp=0", RD_DATA1); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL x0_err got=%b exp=0", ERR); end
        $display("test_x0 done");
    endtask

    task automatic test_orphan();
        RD_ADDR1 = 5'd3; WB_EN = 1'b1; WB_ADDR = 5'd3; WB_DATA = 32'h55; #1;
        checks++; if (RD_DATA1 !== 32'h55 || RD_BUSY1 !== 1'b0) begin errors++; $display("FAIL orphan_bypass got=%h/%b exp=55/0", RD_DATA1, RD_BUSY1); end
        step();
        WB_EN = 1'b0; RSV_ADDR = 5'd3; #1;
        checks++; if (RD_DATA1 !== 32'h55) begin errors++; $display("FAIL orphan_data got=%h exp=55", RD_DATA1); end
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL orphan_err got=%b exp=1", ERR); end
        checks++; if (RD_BUSY1 !== 1'b0 || RSV_READY !== 1'b1) begin errors++; $display("FAIL orphan_pend got=%b/%b exp=0/1", RD_BUSY1, RSV_READY); end
        step(); step();
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL orphan_sticky got=%b exp=1", ERR); end
        $display("test_orphan done");
    endtask

    task automatic test_reset_mid();
        RSV_EN = 1'b1; RSV_ADDR = 5'd4;
        step(); step();
        RSV_EN = 1'b0; RD_ADDR1 = 5'd4; #1;
        checks++; if (RD_BUSY1 !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got=%b exp=1", RD_BUSY1); end
        RESET = 1'b1; WB_EN = 1'b1; WB_ADDR = 5'd4; WB_DATA = 32'h99; RSV_EN = 1'b1; #1;
        checks++; if (RSV_READY !== 1'b0 || RD_BUSY1 !== 1'b0) begin errors++; $display("FAIL rmid_during got=%b/%b exp=0/0", RSV_READY, RD_BUSY1); end
        step();
        RESET = 1'b0; WB_EN = 1'b0; RSV_EN = 1'b0; RD_ADDR2 = 5'd5; #1;
        checks++; if (RD_DATA1 !== 32'h0 || RD_BUSY1 !== 1'b0) begin errors++; $display("FAIL rmid_x4 got=%h/%b exp=0/0", RD_DATA1, RD_BUSY1); end
        checks++; if (RD_DATA2 !== 32'h0) begin errors++; $display("FAIL rmid_x5 got=%h exp=0", RD_DATA2); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rmid_err got=%b exp=0", ERR); end
        checks++; if (RSV_READY !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", RSV_READY); end
        $display("test_reset_mid done");
    endtask

    initial begin
        RESET = 1'b1; RD_ADDR1 = '0; RD_ADDR2 = '0; RSV_EN = 1'b0; RSV_ADDR = '0;
        WB_EN = 1'b0; WB_ADDR = '0; WB_DATA = '0;
        test_reset();
        test_bypass();
        test_saturate();
        test_multi_pending();
        test_x0();
        test_orphan();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
